// File: rtl/alu_sequencer.sv
// alu_sequencer: execution harness around a combinational MIPS-subset ALU.
// Holds a small program memory and the two architectural registers, fetches
// and presents instructions to the ALU, writes results back, resolves
// beq/bne from the ALU zero flag and stops on HALT or at the end of memory.
module alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
  input  logic [31:0]   init_a,
  input  logic [31:0]   init_b,
  output logic [31:0]   alu_instruction,
  output logic [31:0]   alu_regA,
  output logic [31:0]   alu_regB,
  input  logic [31:0]   alu_result,
  input  logic [2:0]    alu_flags,
  output logic          busy,
  output logic          done,
  output logic [31:0]   reg_a_out,
  output logic [31:0]   reg_b_out,
  output logic [AW-1:0] pc_out,
  output logic [15:0]   retired,
  output logic          ovf_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0]   HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

  // Immediate-form ALU ops whose result is written back to the rt field.
  function automatic logic is_imm_op(input logic [5:0] op);
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: is_imm_op = 1'b1;
      default:                                          is_imm_op = 1'b0;
    endcase
  endfunction

  state_t        state_r;
  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   instr_r;
  logic [31:0]   alu_instr_r;
  logic [31:0]   reg_a_r;
  logic [31:0]   reg_b_r;
  logic [AW-1:0] pc_r;
  logic [15:0]   retired_r;
  logic          ovf_r;
  logic          busy_r;
  logic          done_r;

  logic [5:0]    op_s;
  logic [31:0]   fetch_word_s;
  logic          is_halt_s;
  logic          accept_s;
  logic          wb_kind_s;
  logic          wb_s;
  logic [4:0]    dest_s;
  logic          taken_s;
  logic [AW-1:0] target_s;
  logic [15:0]   retired_next_s;
  logic          unused_s;

  // Decode of the instruction in EXEC and of the word addressed by pc.
  always_comb begin
    op_s           = instr_r[31:26];
    fetch_word_s   = mem_r[pc_r];
    is_halt_s      = (fetch_word_s == HALT_WORD);
    accept_s       = (state_r == ST_IDLE) || (state_r == ST_DONE);
    wb_kind_s      = 1'b0;
    dest_s         = 5'd0;
    taken_s        = 1'b0;
    if (op_s == 6'h00) begin
      wb_kind_s = 1'b1;
      dest_s    = instr_r[15:11];
    end else if (is_imm_op(op_s)) begin
      wb_kind_s = 1'b1;
      dest_s    = instr_r[20:16];
    end else begin
      wb_kind_s = 1'b0;
      dest_s    = 5'd0;
    end
    // An overflowing instruction traps: its result is discarded.
    wb_s = wb_kind_s & ~alu_flags[0];
    case (op_s)
      6'h04:   taken_s = alu_flags[2];
      6'h05:   taken_s = ~alu_flags[2];
      default: taken_s = 1'b0;
    endcase
    // Only the low AW offset bits matter since the target wraps modulo DEPTH.
    target_s       = pc_r + AW'(1) + instr_r[AW-1:0];
    retired_next_s = (retired_r == 16'hFFFF) ? retired_r : (retired_r + 16'd1);
  end

  assign unused_s = ^{instr_r, alu_flags[1]};

  // Program memory write port, open only while no run is in progress.
  always_ff @(posedge clk) begin
    if (!reset && accept_s && prog_we) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Sequencer state machine with its registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      instr_r     <= 32'd0;
      alu_instr_r <= 32'd0;
      reg_a_r     <= 32'd0;
      reg_b_r     <= 32'd0;
      pc_r        <= '0;
      retired_r   <= 16'd0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            reg_a_r   <= init_a;
            reg_b_r   <= init_b;
            pc_r      <= '0;
            retired_r <= 16'd0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          instr_r <= fetch_word_s;
          if (is_halt_s) begin
            // HALT is never shown to the ALU; pc stays on the HALT word.
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            alu_instr_r <= fetch_word_s;
            state_r     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_instr_r <= 32'd0;
          retired_r   <= retired_next_s;
          ovf_r       <= ovf_r | alu_flags[0];
          if (wb_s) begin
            if (dest_s == 5'd0) begin
              reg_a_r <= alu_result;
            end else begin
              reg_b_r <= alu_result;
            end
          end
          if (taken_s) begin
            pc_r    <= target_s;
            state_r <= ST_FETCH;
          end else if (pc_r == PC_LAST) begin
            // Falling off the end of memory stops the run instead of wrapping.
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            pc_r    <= pc_r + AW'(1);
            state_r <= ST_FETCH;
          end
        end
        default: begin
          alu_instr_r <= 32'd0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_instruction = alu_instr_r;
  assign alu_regA        = reg_a_r;
  assign alu_regB        = reg_b_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign reg_a_out       = reg_a_r;
  assign reg_b_out       = reg_b_r;
  assign pc_out          = pc_r;
  assign retired         = retired_r;
  assign ovf_sticky      = ovf_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stand-in drives
// alu_result/alu_flags, and a program-level reference model predicts the
// final architectural state, cycle count and instruction stream.
module tb_alu_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [5:0] FUNCTS [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                         6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  localparam logic [5:0] IOPS   [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

  logic          clk = 1'b0;
  logic          reset, prog_we, start;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data, init_a, init_b;
  logic [31:0]   alu_instruction, alu_regA, alu_regB, alu_result;
  logic [2:0]    alu_flags;
  logic          busy, done, ovf_sticky;
  logic [31:0]   reg_a_out, reg_b_out;
  logic [AW-1:0] pc_out;
  logic [15:0]   retired;

  int checks = 0;
  int errors = 0;
  int last_edges;

  logic [31:0] prog [DEPTH];
  logic [31:0] exp_trace [$];
  logic [31:0] m_a, m_b;
  int          m_pc, m_ret, m_cyc;
  logic        m_ovf;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .init_a(init_a), .init_b(init_b),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy), .done(done),
    .reg_a_out(reg_a_out), .reg_b_out(reg_b_out), .pc_out(pc_out),
    .retired(retired), .ovf_sticky(ovf_sticky)
  );

  // Behavioural MIPS-subset ALU: returns {zero, negative, overflow, result}.
  function automatic logic [34:0] alu_model(input logic [31:0] ins, input logic [31:0] ra,
                                            input logic [31:0] rb);
    logic [31:0] s, t, r, si, zi;
    logic v;
    s  = (ins[25:21] == 5'd0) ? ra : rb;
    t  = (ins[20:16] == 5'd0) ? ra : rb;
    si = {{16{ins[15]}}, ins[15:0]};
    zi = {16'h0000, ins[15:0]};
    r  = 32'd0;
    v  = 1'b0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h00: r = t << ins[10:6];
          6'h02: r = t >> ins[10:6];
          6'h03: r = $unsigned($signed(t) >>> ins[10:6]);
          6'h20: begin r = s + t; v = (s[31] == t[31]) && (r[31] != s[31]); end
          6'h21: r = s + t;
          6'h22: begin r = s - t; v = (s[31] != t[31]) && (r[31] != s[31]); end
          6'h23: r = s - t;
          6'h24: r = s & t;
          6'h25: r = s | t;
          6'h26: r = s ^ t;
          6'h27: r = ~(s | t);
          6'h2A: r = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
          6'h2B: r = (s < t) ? 32'd1 : 32'd0;
          default: r = 32'd0;
        endcase
      end
      6'h08: begin r = s + si; v = (s[31] == si[31]) && (r[31] != s[31]); end
      6'h09: r = s + si;
      6'h0A: r = ($signed(s) < $signed(si)) ? 32'd1 : 32'd0;
      6'h0B: r = (s < si) ? 32'd1 : 32'd0;
      6'h0C: r = s & zi;
      6'h0D: r = s | zi;
      6'h0E: r = s ^ zi;
      6'h04, 6'h05: r = s - t;
      6'h23, 6'h2B: r = s + si;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r[31], v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_instruction, alu_regA, alu_regB);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Program-level reference: walk the program, applying the sequencing rules.
  task automatic run_model(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a, b, w, r;
    logic [2:0]  f;
    logic [5:0]  op;
    int pc, dest, npc;
    bit taken;
    a = a0; b = b0; pc = 0;
    m_ret = 0; m_cyc = 0; m_ovf = 1'b0;
    exp_trace.delete();
    for (int step = 0; step < 1000; step++) begin
      w = prog[pc];
      if (w == 32'hFFFF_FFFF) begin
        exp_trace.push_back(32'd0);
        exp_trace.push_back(32'd0);
        m_cyc += 1;
        break;
      end
      {f, r} = alu_model(w, a, b);
      exp_trace.push_back(32'd0);
      exp_trace.push_back(w);
      m_cyc += 2;
      m_ret++;
      if (f[0]) m_ovf = 1'b1;
      op = w[31:26];
      dest = -1;
      if (!f[0]) begin
        if (op == 6'h00) dest = int'(w[15:11]);
        else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) dest = int'(w[20:16]);
      end
      if (dest == 0) a = r;
      else if (dest > 0) b = r;
      taken = (op == 6'h04 && f[2]) || (op == 6'h05 && !f[2]);
      if (taken) begin
        npc = pc + 1 + int'($signed(w[15:0]));
        pc = ((npc % DEPTH) + DEPTH) % DEPTH;
      end else if (pc == DEPTH - 1) begin
        exp_trace.push_back(32'd0);
        break;
      end else begin
        pc++;
      end
    end
    m_a = a; m_b = b; m_pc = pc;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input string tag, input logic [31:0] a0, input logic [31:0] b0,
                          input bit disturb);
    int edges;
    logic [31:0] trace [$];
    run_model(a0, b0);
    @(negedge clk);
    init_a = a0; init_b = b0; start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      trace.push_back(alu_instruction);
      if (edges == 1) start = 1'b0;
      if (disturb && edges == 2) begin
        prog_we = 1'b1; prog_addr = AW'(1); prog_data = 32'h2000_0007;
        start = 1'b1; init_a = 32'h1234_5678;
      end
      if (disturb && edges == 5) begin
        prog_we = 1'b0; start = 1'b0; init_a = a0;
      end
    end while (!done && edges < 300);
    last_edges = edges;
    check({tag, "/done"}, done, 1);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/reg_a"}, reg_a_out, m_a);
    check({tag, "/reg_b"}, reg_b_out, m_b);
    check({tag, "/pc"}, pc_out, m_pc);
    check({tag, "/retired"}, retired, m_ret);
    check({tag, "/ovf"}, ovf_sticky, m_ovf);
    check({tag, "/cycles"}, edges - 1, m_cyc);
    check({tag, "/trace_len"}, trace.size(), exp_trace.size());
    if (trace.size() == exp_trace.size()) begin
      for (int i = 0; i < trace.size(); i++) check({tag, "/alu_instr"}, trace[i], exp_trace[i]);
    end
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  // Random instruction for slot i; branches only jump forward inside memory.
  function automatic logic [31:0] rand_instr(input int i);
    int kind;
    logic [5:0] fn;
    logic [4:0] sh;
    kind = $urandom_range(0, 11);
    if (kind == 9 && i > DEPTH - 2) kind = 5;
    case (kind)
      0: return 32'hFFFF_FFFF;
      1, 2, 3, 4: begin
        fn = FUNCTS[$urandom_range(0, 12)];
        sh = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 5'($urandom_range(0, 31)) : 5'd0;
        return {6'h00, rand_reg(), rand_reg(), rand_reg(), sh, fn};
      end
      5, 6, 7, 8: return {IOPS[$urandom_range(0, 6)], rand_reg(), rand_reg(), 16'($urandom())};
      9: return {($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rand_reg(), rand_reg(),
                 16'($urandom_range(0, DEPTH - 2 - i))};
      10: return {($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B, rand_reg(), rand_reg(), 16'($urandom())};
      default: return {6'h00, 5'd0, rand_reg(), rand_reg(), 5'($urandom_range(0, 31)), 6'h00};
    endcase
  endfunction

  task automatic set_prog1();
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hFFFF_FFFF;
    prog[0] = 32'h2000_0005; prog[1] = 32'h2021_FFFD; prog[2] = 32'h0001_0020;
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_data = 32'd0; init_a = 32'd0; init_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/reg_a", reg_a_out, 0);
    check("rst/reg_b", reg_b_out, 0);
    check("rst/pc", pc_out, 0);
    check("rst/retired", retired, 0);
    check("rst/ovf", ovf_sticky, 0);
    check("rst/alu_instr", alu_instruction, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic addi/add program.
    set_prog1();
    load_prog();
    run_prog("s1", 32'd0, 32'd0, 1'b0);
    check("s1/edges", last_edges, 8);
    check("s1/reg_a_const", reg_a_out, 32'd2);
    check("s1/reg_b_const", reg_b_out, 32'hFFFF_FFFD);
    check("s1/retired_const", retired, 3);

    // Overflow suppresses writeback but sets the sticky flag.
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hFFFF_FFFF;
    prog[0] = 32'h0001_0020;
    load_prog();
    run_prog("ovf", 32'h7FFF_FFFF, 32'd1, 1'b0);
    check("ovf/reg_a_const", reg_a_out, 32'h7FFF_FFFF);
    check("ovf/sticky_const", ovf_sticky, 1);

    // beq taken / bne not taken.
    prog[0] = 32'h1001_0001; prog[1] = 32'h2000_0001; prog[2] = 32'hFFFF_FFFF;
    load_prog();
    run_prog("beq", 32'd7, 32'd7, 1'b0);
    check("beq/reg_a_const", reg_a_out, 32'd7);
    check("beq/retired_const", retired, 1);
    prog[0] = 32'h1401_0001;
    load_prog();
    run_prog("bne", 32'd7, 32'd7, 1'b0);
    check("bne/reg_a_const", reg_a_out, 32'd8);
    check("bne/pc_const", pc_out, 2);

    // No HALT: run stops at the last word.
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'h2000_0001;
    load_prog();
    run_prog("full", 32'd0, 32'd0, 1'b0);
    check("full/reg_a_const", reg_a_out, 32'd16);
    check("full/pc_const", pc_out, 15);
    check("full/cycles_const", last_edges - 1, 32);

    // Backward branch wrapping below address 0.
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hFFFF_FFFF;
    prog[0] = 32'h1000_FFFE;
    load_prog();
    run_prog("wrap", 32'd5, 32'd5, 1'b0);
    check("wrap/pc_const", pc_out, 15);

    // Reset in EXEC of the second instruction, then rerun from retained memory.
    set_prog1();
    load_prog();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst/in_exec", alu_instruction, 32'h2021_FFFD);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst/busy", busy, 0);
    check("midrst/reg_a", reg_a_out, 0);
    check("midrst/pc", pc_out, 0);
    check("midrst/alu_instr", alu_instruction, 0);
    run_prog("rerun", 32'd0, 32'd0, 1'b0);
    check("rerun/reg_a_const", reg_a_out, 32'd2);

    // Program writes and start pulses while busy are ignored.
    run_prog("disturb", 32'd0, 32'd0, 1'b1);
    run_prog("after_disturb", 32'd0, 32'd0, 1'b0);
    check("after_disturb/reg_b_const", reg_b_out, 32'hFFFF_FFFD);

    // Random programs against the reference model.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEPTH; i++) prog[i] = rand_instr(i);
      load_prog();
      run_prog($sformatf("rand%0d", n), $urandom(), $urandom(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Drives the combinational MIPS-subset ALU from its input side and consumes its outputs. Holds a small program memory and the two architectural registers (regA at address 00000, regB at any other address). Fetches instructions, presents instruction/regA/regB to the ALU, writes results back, resolves beq/bne from the zero flag, and halts. It is the execution harness around the ALU for standalone program runs.

Parameters:
DEPTH, 16, program memory words; power of two, 2..256
AW, 4, log2(DEPTH); PC and program address width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
prog_we  in  1  program write strobe; honoured only when busy=0
prog_addr  in  AW  program write address
prog_data  in  32  program write data
start  in  1  run request; honoured only when busy=0
init_a  in  32  regA initial value, latched on accepted start
init_b  in  32  regB initial value, latched on accepted start
alu_instruction  out  32  instruction to ALU
alu_regA  out  32  current regA to ALU
alu_regB  out  32  current regB to ALU
alu_result  in  32  ALU result (combinational from the three outputs above)
alu_flags  in  3  ALU flags: [2] zero, [1] negative, [0] overflow
busy  out  1  high in FETCH and EXEC
done  out  1  high in DONE
reg_a_out  out  32  regA
reg_b_out  out  32  regB
pc_out  out  AW  program counter
retired  out  16  executed-instruction count, saturates at 0xFFFF
ovf_sticky  out  1  set on any executed instruction with alu_flags[0]=1

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs): state=IDLE; regA, regB, pc, retired, ovf_sticky = 0; busy=done=0; instr_reg=0. Program memory is not cleared.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE/DONE: prog_we writes mem[prog_addr]. On start: regA=init_a, regB=init_b, pc=0, retired=0, ovf_sticky=0, go to FETCH. If prog_we and start occur together, the write completes and is visible to the run.
- FETCH (1 cycle): instr_reg <= mem[pc]. If mem[pc]==32'hFFFF_FFFF (HALT), go to DONE; pc is unchanged and retired is not incremented. Otherwise go to EXEC.
- EXEC (1 cycle): alu_instruction=instr_reg. Sample alu_result and alu_flags at the end of the cycle, then:
  - R-type (op==0), writeback destination = instr[15:11].
  - addi/addiu/andi/ori/xori/slti/sltiu (op 08,09,0C,0D,0E,0A,0B), writeback destination = instr[20:16].
  - Destination 00000 writes regA; any other destination writes regB.
  - Writeback is suppressed when alu_flags[0]=1 (signed overflow trap semantics). ovf_sticky is still set.
  - beq (op 04): taken if flags[2]=1. bne (op 05): taken if flags[2]=0. Taken: pc <= pc+1+sext(instr[15:0]), truncated to AW bits (wraps modulo DEPTH). No writeback.
  - lw/sw (op 23/2B): no writeback, no memory access; treated as retired no-ops.
  - Otherwise pc <= pc+1.
  - retired increments, saturating at 0xFFFF.
  - If pc==DEPTH-1 and no taken branch, go to DONE after EXEC instead of wrapping. Otherwise go to FETCH.
- Two cycles per instruction. Program memory is asynchronous read.
- Outside EXEC, alu_instruction=32'h0000_0000 (sll, recognised by the ALU). HALT is never presented to the ALU. Any other opcode the ALU does not recognise is a program error and is not checked here.
- alu_regA/alu_regB always equal regA/regB.
- DONE persists until reset or a new start. prog_we and start are ignored while busy.

Test Plan:
- Program [0x20000005, 0x2021FFFD, 0x00010020, HALT], init_a=init_b=0, start -> the 8th edge after start enters DONE; reg_a=2, reg_b=0xFFFFFFFD, retired=3, ovf_sticky=0.
- init_a=0x7FFFFFFF, init_b=1, program [0x00010020, HALT] -> reg_a stays 0x7FFFFFFF, ovf_sticky=1, retired=1.
- init_a=init_b=7, program [0x10010001 beq +1, 0x20000001, HALT] -> reg_a=7, retired=1. Same program with op bne (0x14010001) -> reg_a=8, retired=2, pc_out=2 at done.
- DEPTH=16, all words 0x20000001, no HALT -> done after 32 busy cycles, reg_a=16, retired=16, pc_out=15. Branch 0x1000FFFE at pc=0 with equal regs -> target wraps to pc=15.
- Reset asserted during EXEC of the second instruction -> next cycle busy=0, reg_a=0, pc_out=0, alu_instruction=0. Re-start reproduces scenario 1 results (memory retained).
- prog_we to addr 1 and start pulses while busy -> no effect on the run; memory word unchanged, results identical to the undisturbed run.
